// File: rtl/card_pkg.sv
// Shared types and default deck geometry for the card dealer and its counter.
package card_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DEAL  = 2'd2,
    ST_DENY  = 2'd3
  } state_e;

  localparam int CARD_MIN   = 1;
  localparam int CARD_MAX   = 10;
  localparam int COPIES     = 4;
  localparam int MAX_COPIES = 16;
  localparam int DECK_SIZE  = COPIES * (CARD_MAX - CARD_MIN) + MAX_COPIES;

  // Successor of a card value, wrapping from the top value back to the bottom one.
  function automatic int next_card(input int v, input int lo = CARD_MIN, input int hi = CARD_MAX);
    return (v >= hi) ? lo : v + 1;
  endfunction

endpackage

// File: rtl/card_counter.sv
// Free-running entropy counter: steps CARD_MIN..CARD_MAX while enabled, holds otherwise.
module card_counter #(
  parameter int CARD_MIN = card_pkg::CARD_MIN,
  parameter int CARD_MAX = card_pkg::CARD_MAX,
  parameter int W        = 5
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         enable_i,
  output logic [W-1:0] value_o
);
  import card_pkg::*;

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (enable_i) begin
      value_d = W'(next_card(int'(value_q), CARD_MIN, CARD_MAX));
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      value_q <= W'(CARD_MIN);
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/card_dealer.sv
// Finite-deck card dealer: arbitrates hand requests, probes the deck from the
// entropy counter upward, and deals or denies one card per grant.
module card_dealer #(
  parameter int CARD_MIN   = card_pkg::CARD_MIN,
  parameter int CARD_MAX   = card_pkg::CARD_MAX,
  parameter int COPIES     = card_pkg::COPIES,
  parameter int MAX_COPIES = card_pkg::MAX_COPIES,
  parameter int NUM_CH     = 2,
  parameter int W          = 5,
  parameter int TW         = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              shuffle,
  input  logic [NUM_CH-1:0] draw_req,
  output logic [W-1:0]      card,
  output logic [NUM_CH-1:0] card_valid,
  output logic [NUM_CH-1:0] deny,
  output logic [TW-1:0]     remaining,
  output logic              busy
);
  import card_pkg::*;

  localparam int NV   = CARD_MAX - CARD_MIN + 1;
  localparam int DECK = COPIES * (CARD_MAX - CARD_MIN) + MAX_COPIES;
  localparam int CW   = $clog2(((COPIES > MAX_COPIES) ? COPIES : MAX_COPIES) + 1);
  localparam int IW   = (NV > 1) ? $clog2(NV) : 1;
  localparam int PW   = $clog2(NV + 1);
  localparam int GW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] CHECK = ST_CHECK;
  localparam logic [1:0] DEAL  = ST_DEAL;
  localparam logic [1:0] DENY  = ST_DENY;

  logic [1:0]        state_q,      state_d;
  logic [GW-1:0]     grant_q,      grant_d;
  logic [W-1:0]      cand_q,       cand_d;
  logic [PW-1:0]     probes_q,     probes_d;
  logic [NUM_CH-1:0] pending_q,    pending_d;
  logic [W-1:0]      card_q,       card_d;
  logic [NUM_CH-1:0] card_valid_q, card_valid_d;
  logic [NUM_CH-1:0] deny_q,       deny_d;
  logic [TW-1:0]     remaining_q;
  logic [CW-1:0]     count_q [NV];

  logic [W-1:0]      counter_val;
  logic [IW-1:0]     cand_idx;
  logic              hit;
  logic              dec;
  logic [GW-1:0]     low_idx;
  logic [NUM_CH-1:0] clear_mask;

  card_counter #(
    .CARD_MIN (CARD_MIN),
    .CARD_MAX (CARD_MAX),
    .W        (W)
  ) u_counter (
    .clock_i  (clock),
    .reset_i  (reset),
    .enable_i (enable),
    .value_o  (counter_val)
  );

  assign cand_idx = IW'(cand_q - W'(CARD_MIN));
  assign hit      = (count_q[cand_idx] != '0);

  // Fixed priority: the lowest-numbered pending hand wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = GW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cand_d       = cand_q;
    probes_d     = probes_q;
    card_d       = card_q;
    card_valid_d = '0;
    deny_d       = '0;
    dec          = 1'b0;
    clear_mask   = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d = low_idx;
          if (remaining_q == '0) begin
            state_d = DENY;
          end else begin
            cand_d   = counter_val;
            probes_d = '0;
            state_d  = CHECK;
          end
        end
      end
      CHECK: begin
        // The pulse is launched on the hit edge so it is visible during DEAL.
        if (hit) begin
          dec                   = 1'b1;
          card_d                = cand_q;
          card_valid_d[grant_q] = 1'b1;
          state_d               = DEAL;
        end else if (probes_q == PW'(NV - 1)) begin
          state_d = DENY;
        end else begin
          cand_d   = W'(next_card(int'(cand_q), CARD_MIN, CARD_MAX));
          probes_d = probes_q + PW'(1);
        end
      end
      DEAL: begin
        clear_mask[grant_q] = 1'b1;
        state_d             = IDLE;
      end
      default: begin
        deny_d[grant_q]     = 1'b1;
        clear_mask[grant_q] = 1'b1;
        state_d             = IDLE;
      end
    endcase
    pending_d = (pending_q & ~clear_mask) | draw_req;
  end

  always_ff @(posedge clock) begin
    if (reset || shuffle) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      card_valid_q <= '0;
      deny_q       <= '0;
      remaining_q  <= TW'(DECK);
      for (int i = 0; i < NV; i++) begin
        count_q[i] <= (i == NV - 1) ? CW'(MAX_COPIES) : CW'(COPIES);
      end
      if (reset) begin
        card_q   <= '0;
        grant_q  <= '0;
        cand_q   <= W'(CARD_MIN);
        probes_q <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cand_q       <= cand_d;
      probes_q     <= probes_d;
      pending_q    <= pending_d;
      card_q       <= card_d;
      card_valid_q <= card_valid_d;
      deny_q       <= deny_d;
      if (dec) begin
        remaining_q        <= remaining_q - TW'(1);
        count_q[cand_idx]  <= count_q[cand_idx] - CW'(1);
      end
    end
  end

  assign card       = card_q;
  assign card_valid = card_valid_q;
  assign deny       = deny_q;
  assign remaining  = remaining_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: transaction-level deck model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       shuffle = 1'b0;
  logic [1:0] draw_req = 2'b00;
  logic [4:0] card;
  logic [1:0] card_valid;
  logic [1:0] deny;
  logic [5:0] remaining;
  logic       busy;

  int checks = 0;
  int errors = 0;

  card_dealer dut (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .shuffle    (shuffle),
    .draw_req   (draw_req),
    .card       (card),
    .card_valid (card_valid),
    .deny       (deny),
    .remaining  (remaining),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Deck model: counts per value, a request latch per hand, and one job at a
  // time whose card and pulse time are decided when the hand is granted.
  int         m_cnt [1:10];
  int         m_rem, m_ctr, m_timer, m_hand, m_val, m_v, m_k;
  logic [1:0] m_pend, m_clr;
  bit         m_job, m_tail, m_is_deny, m_ok;
  int         e_card;
  logic [1:0] e_valid, e_deny;

  always @(posedge clk) begin
    m_clr = 2'b00;
    if (reset) begin
      for (int v = 1; v <= 10; v++) m_cnt[v] = (v == 10) ? 16 : 4;
      m_rem = 52; m_ctr = 1; m_pend = 2'b00; m_job = 0; m_tail = 0;
      e_card = 0; e_valid = 2'b00; e_deny = 2'b00; m_ok = 1;
    end else begin
      e_valid = 2'b00;
      e_deny  = 2'b00;
      if (shuffle) begin
        for (int v = 1; v <= 10; v++) m_cnt[v] = (v == 10) ? 16 : 4;
        m_rem = 52; m_pend = 2'b00; m_job = 0; m_tail = 0;
      end else begin
        if (m_job) begin
          if (m_tail) begin
            m_job = 0; m_clr[m_hand] = 1'b1;
          end else begin
            m_timer--;
            if (m_timer == 0) begin
              if (m_is_deny) begin
                e_deny[m_hand] = 1'b1; m_job = 0; m_clr[m_hand] = 1'b1;
              end else begin
                e_valid[m_hand] = 1'b1; e_card = m_val;
                m_cnt[m_val]--; m_rem--; m_tail = 1;
              end
            end
          end
        end else if (m_pend != 2'b00) begin
          m_hand = m_pend[0] ? 0 : 1;
          m_job = 1; m_tail = 0;
          if (m_rem == 0) begin
            m_is_deny = 1; m_timer = 1;
          end else begin
            m_is_deny = 0; m_v = m_ctr; m_k = 0;
            while (m_cnt[m_v] == 0) begin
              m_v = (m_v == 10) ? 1 : m_v + 1; m_k++;
            end
            m_val = m_v; m_timer = 1 + m_k;
          end
        end
        m_pend = (m_pend & ~m_clr) | draw_req;
      end
      if (enable) m_ctr = (m_ctr == 10) ? 1 : m_ctr + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one cycle and compare every output with the model mid-cycle.
  task automatic tick();
    @(negedge clk);
    if (m_ok) begin
      chk("model_card", 32'(card), 32'(e_card));
      chk("model_valid", 32'(card_valid), 32'(e_valid));
      chk("model_deny", 32'(deny), 32'(e_deny));
      chk("model_remaining", 32'(remaining), 32'(m_rem));
      chk("model_busy", 32'(busy), 32'(m_job));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic draw_and_wait(input logic [1:0] r, output int at);
    draw_req = r; tick(); draw_req = 2'b00; at = 1;
    while (card_valid == 2'b00 && deny == 2'b00 && at < 60) begin tick(); at++; end
    if (at >= 60) chk("pulse_timeout", 0, 1);
    $display("draw req=%b cycle=%0d card=%0d valid=%b deny=%b rem=%0d",
             r, at, card, card_valid, deny, remaining);
  endtask

  task automatic wait_next(inout int at);
    tick(); at++;
    while (card_valid == 2'b00 && deny == 2'b00 && at < 60) begin tick(); at++; end
    if (at >= 60) chk("pulse_timeout", 0, 1);
    $display("next pulse cycle=%0d card=%0d valid=%b deny=%b rem=%0d",
             at, card, card_valid, deny, remaining);
  endtask

  task automatic draw_n(input logic [1:0] r, input int n);
    int got, budget;
    got = 0; budget = 0;
    draw_req = r;
    while (got < n && budget < 2000) begin
      tick(); budget++;
      if (card_valid != 2'b00) got++;
    end
    draw_req = 2'b00;
    if (got < n) chk("draw_n_timeout", 32'(got), 32'(n));
    $display("level draws req=%b dealt=%0d card=%0d rem=%0d", r, got, card, remaining);
  endtask

  task automatic do_shuffle();
    shuffle = 1'b1; tick(); shuffle = 1'b0;
    chk("shuffle_remaining", 32'(remaining), 52);
  endtask

  int at;

  initial begin
    // Reset
    reset = 1'b1; idle(2);
    chk("rst_card", 32'(card), 0);
    chk("rst_remaining", 32'(remaining), 52);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(card_valid), 0);
    chk("rst_deny", 32'(deny), 0);
    reset = 1'b0; idle(1);

    // Single draw
    draw_and_wait(2'b01, at);
    chk("single_cycle", 32'(at), 3);
    chk("single_card", 32'(card), 1);
    chk("single_valid", 32'(card_valid), 2'b01);
    chk("single_remaining", 32'(remaining), 51);
    idle(2);

    // Skip after value 1 is exhausted
    do_shuffle();
    for (int i = 0; i < 4; i++) begin
      draw_and_wait(2'b01, at);
      chk("skip_pre_cycle", 32'(at), 3);
      chk("skip_pre_card", 32'(card), 1);
      idle(1);
    end
    draw_and_wait(2'b01, at);
    chk("skip_cycle", 32'(at), 4);
    chk("skip_card", 32'(card), 2);
    chk("skip_remaining", 32'(remaining), 47);
    idle(2);

    // Arbitration
    do_shuffle();
    draw_and_wait(2'b11, at);
    chk("arb0_cycle", 32'(at), 3);
    chk("arb0_valid", 32'(card_valid), 2'b01);
    chk("arb0_card", 32'(card), 1);
    wait_next(at);
    chk("arb1_cycle", 32'(at), 6);
    chk("arb1_valid", 32'(card_valid), 2'b10);
    chk("arb1_card", 32'(card), 1);
    chk("arb_remaining", 32'(remaining), 50);
    idle(2);

    // Empty deck
    do_shuffle();
    draw_n(2'b01, 52);
    idle(2);
    chk("empty_remaining", 32'(remaining), 0);
    chk("empty_last_card", 32'(card), 10);
    draw_and_wait(2'b10, at);
    chk("deny_cycle", 32'(at), 3);
    chk("deny_hand", 32'(deny), 2'b10);
    chk("deny_no_valid", 32'(card_valid), 0);
    chk("deny_card_kept", 32'(card), 10);
    idle(2);

    // Counter wrap
    reset = 1'b1; idle(2); reset = 1'b0;
    enable = 1'b1; idle(10); enable = 1'b0;
    draw_and_wait(2'b01, at);
    chk("wrap_full_card", 32'(card), 1);
    idle(2);
    enable = 1'b1; idle(9); enable = 1'b0;
    draw_and_wait(2'b01, at);
    chk("wrap_top_card", 32'(card), 10);
    chk("wrap_top_cycle", 32'(at), 3);
    idle(2);
    enable = 1'b1; idle(1); enable = 1'b0;
    draw_and_wait(2'b01, at);
    chk("wrap_back_card", 32'(card), 1);
    idle(2);

    // Shuffle during CHECK
    do_shuffle();
    draw_n(2'b01, 36);
    idle(2);
    chk("deplete_remaining", 32'(remaining), 16);
    draw_req = 2'b01; tick(); draw_req = 2'b00;
    tick();
    chk("check_busy", 32'(busy), 1);
    shuffle = 1'b1; tick(); shuffle = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_remaining", 32'(remaining), 52);
    chk("abort_card_kept", 32'(card), 9);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("abort_no_valid", 32'(card_valid), 0);
    end
    $display("shuffle abort done rem=%0d busy=%0d", remaining, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
